reg_serial_reader: RTL and testbench
====================================

// Module: reg_serial_reader
// PURPOSE
//   Reader end of the processor's enable-loaded N-bit registers.
//   - On a Start request, captures a register's parallel output and streams it out one bit at a time.
//   - Each bit moves over a valid/ready handshake.
//   - Used by the debug/readback path to observe datapath registers without widening the bus.
// PARAMETERS
//   N          8   register width in bits (N >= 2)
//   MSB_FIRST  0   0: bit 0 transmitted first; 1: bit N-1 first
// PORTS
//   clk     in   1   system clock; all state updates on rising edge
//   reset   in   1   asynchronous, active-low; 0 forces reset state immediately
//   Start   in   1   request a readback; sampled only in IDLE
//   Din     in   N   parallel register value; captured on the edge that accepts Start
//   Sout    out  1   current serial bit
//   Svalid  out  1   Sout holds a valid bit
//   Sready  in   1   sink accepts the bit; transfer = Svalid & Sready at a rising edge
//   Busy    out  1   high in SHIFT and DONE
//   Done    out  1   one-cycle pulse after the last bit has been transferred
// BEHAVIOUR
//   Reset (reset=0, asynchronous):
//     - State=IDLE; shift reg and bit counter = 0.
//     - Sout=0, Svalid=0, Busy=0, Done=0.
//     - Takes effect mid-transfer too; the partial word is discarded and no Done is produced.
//   FSM, registered, states IDLE, SHIFT, DONE:
//     IDLE  -> SHIFT on Start=1: shift reg <= Din, counter <= N-1.
//     SHIFT -> SHIFT on each transfer while counter != 0: shift 1 position, counter -= 1.
//     SHIFT -> DONE on the transfer with counter == 0.
//     DONE  -> IDLE unconditionally after 1 cycle.
//   Outputs (all registered or decoded from state; no combinational path Sready->Svalid):
//     - Svalid = (state==SHIFT).
//     - Sout = shift reg bit 0 when MSB_FIRST=0, bit N-1 when MSB_FIRST=1.
//     - Busy = (state!=IDLE). Done = (state==DONE).
//   Latency:
//     - Start sampled at edge k -> Svalid=1 and first bit on Sout after edge k.
//     - With Sready held 1: N transfer cycles, then Done high for 1 cycle.
//     - Start-to-Done = N+1 cycles; back-to-back Start accepted again after N+2 cycles.
//   Stall: Svalid=1 & Sready=0 -> Sout, counter and shift reg all hold; no timeout.
//   Start while Busy: ignored, no queueing; Din changes while Busy have no effect.
//   Start and the DONE->IDLE step in the same cycle: Start ignored (only sampled in IDLE).
//   Counter: width $clog2(N); no wrap, since the counter never decrements below 0.
//   Sready while Svalid=0: ignored.
// STRUCTURE
//   Shared include ssp_defs.vh:
//     - FSM state encodings: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
//     - Default width constant SSP_WIDTH=8, shared with the register and datapath blocks.
//   Sub-module bit_down_counter #(W):
//     - Ports clk, reset, Load, Dec, Lval[W-1:0], Zero.
//     - Async active-low reset.
//   Top level: FSM, shift register, output decode.
// TESTING
//   - Reset: reset=0 with Start=1, Din=8'hFF -> Svalid=0, Busy=0, Done=0, Sout=0 throughout.
//   - Basic readback, N=8, MSB_FIRST=0, Din=8'hA5, Sready=1:
//       Sout sequence 1,0,1,0,0,1,0,1 over 8 cycles.
//       Done pulses at cycle 9 after Start; Busy falls at cycle 10.
//   - MSB_FIRST=1, Din=8'hA5 -> Sout sequence 1,0,1,0,0,1,0,1 (palindrome check).
//     Then Din=8'h01 -> seven 0s followed by one 1.
//   - Backpressure, Din=8'h3C:
//       Sready low for 3 cycles after the 2nd bit -> Sout/Svalid held stable.
//       Total 8 transfers, Done 1 cycle after the 8th.
//   - Start pulsed during SHIFT with Din=8'h00 -> ignored; original word 8'hC3 streams intact.
//   - Reset asserted after 4 bits of 8'hF0 -> immediate Svalid=0, no Done.
//     Next Start with Din=8'h0F streams a full fresh word.

Source files
------------

// File: rtl/reg_serial_reader_pkg.sv
// Shared definitions for the register readback serializer: FSM state encodings
// and the default register width used across the register and datapath blocks.
package reg_serial_reader_pkg;

    localparam int SSP_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/reg_serial_reader_if.sv
// Readback bus: Start/Din request side plus the bit-serial valid/ready stream and status.
// The master modport is the reader; the slave modport is the requester/sink side.
interface reg_serial_reader_if
    import reg_serial_reader_pkg::*;
#(
    parameter int N = SSP_WIDTH
);
    logic         Start;
    logic [N-1:0] Din;
    logic         Sout;
    logic         Svalid;
    logic         Sready;
    logic         Busy;
    logic         Done;

    modport master (
        input  Start, Din, Sready,
        output Sout, Svalid, Busy, Done
    );

    modport slave (
        output Start, Din, Sready,
        input  Sout, Svalid, Busy, Done
    );
endinterface

// File: rtl/reg_serial_reader_bit_down_counter.sv
// Loadable down-counter that flags zero; Load has priority over Dec.
// Latency: count updates on the edge after Load/Dec. No backpressure of its own.
module bit_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Load,
    input  logic         Dec,
    input  logic [W-1:0] Lval,
    output logic         Zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Load) begin
            cnt_d = Lval;
        end else if (Dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Zero = (cnt_q == '0);
endmodule

// File: rtl/reg_serial_reader.sv
// Captures Din on an accepted Start and streams it one bit per valid/ready transfer.
// Latency: first bit valid the cycle after Start; Done pulses one cycle after the last transfer.
// Backpressure: Sready low holds Sout, shift reg and counter; Start is ignored while Busy.
module reg_serial_reader
    import reg_serial_reader_pkg::*;
#(
    parameter int N         = SSP_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    reg_serial_reader_if.master bus
);
    localparam int              CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_e       state_q, state_d;
    logic [N-1:0] shift_q, shift_d;
    logic         cnt_load;
    logic         cnt_dec;
    logic         cnt_zero;

    bit_down_counter #(
        .W (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .Load  (cnt_load),
        .Dec   (cnt_dec),
        .Lval  (LAST),
        .Zero  (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d  = ST_SHIFT;
                    shift_d  = bus.Din;
                    cnt_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.Sready) begin
                    // The final transfer leaves the shift reg untouched; only the state moves on.
                    if (cnt_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_dec = 1'b1;
                        shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    assign bus.Svalid = (state_q == ST_SHIFT);
    assign bus.Busy   = (state_q != ST_IDLE);
    assign bus.Done   = (state_q == ST_DONE);
    assign bus.Sout   = MSB_FIRST ? shift_q[N-1] : shift_q[0];
endmodule

// File: tb/tb_reg_serial_reader.sv
// Directed bench for reg_serial_reader: one LSB-first and one MSB-first instance,
// stimulus driven 1 ns after each rising edge and outputs sampled there too.
module tb_reg_serial_reader;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reg_serial_reader_if #(.N(8)) bus0 ();
    reg_serial_reader_if #(.N(8)) bus1 ();

    reg_serial_reader #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    reg_serial_reader #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus0.Start  = 1'b1;
        bus0.Din    = 8'hFF;
        bus0.Sready = 1'b1;
        bus1.Start  = 1'b1;
        bus1.Din    = 8'hFF;
        bus1.Sready = 1'b1;
        #2;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({bus0.Svalid, bus0.Busy, bus0.Done, bus0.Sout} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_lsb cyc=%0d got {Svalid,Busy,Done,Sout}=%b want 0000", c,
                         {bus0.Svalid, bus0.Busy, bus0.Done, bus0.Sout});
            end
            total++;
            if ({bus1.Svalid, bus1.Busy, bus1.Done, bus1.Sout} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_msb cyc=%0d got {Svalid,Busy,Done,Sout}=%b want 0000", c,
                         {bus1.Svalid, bus1.Busy, bus1.Done, bus1.Sout});
            end
            tick();
        end
        bus0.Start = 1'b0;
        bus1.Start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        exp        = 8'hA5;
        bus0.Din   = exp;
        bus0.Start = 1'b1;
        tick();
        bus0.Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus0.Svalid !== 1'b1 || bus0.Sout !== exp[i]) begin
                bad++;
                $display("FAIL basic_bit%0d got Svalid=%b Sout=%b want Svalid=1 Sout=%b",
                         i, bus0.Svalid, bus0.Sout, exp[i]);
            end
            tick();
        end
        total++;
        if (bus0.Done !== 1'b1 || bus0.Busy !== 1'b1 || bus0.Svalid !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got Done=%b Busy=%b Svalid=%b want 1 1 0",
                     bus0.Done, bus0.Busy, bus0.Svalid);
        end
        tick();
        total++;
        if (bus0.Done !== 1'b0 || bus0.Busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got Done=%b Busy=%b want 0 0", bus0.Done, bus0.Busy);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] words [2];
        logic [7:0] exp;
        words[0] = 8'hA5;
        words[1] = 8'h01;
        for (int w = 0; w < 2; w++) begin
            exp        = words[w];
            bus1.Din   = exp;
            bus1.Start = 1'b1;
            tick();
            bus1.Start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                total++;
                if (bus1.Svalid !== 1'b1 || bus1.Sout !== exp[7-i]) begin
                    bad++;
                    $display("FAIL msb_w%0d_bit%0d got Svalid=%b Sout=%b want Svalid=1 Sout=%b",
                             w, i, bus1.Svalid, bus1.Sout, exp[7-i]);
                end
                tick();
            end
            total++;
            if (bus1.Done !== 1'b1) begin
                bad++;
                $display("FAIL msb_w%0d_done got Done=%b want 1", w, bus1.Done);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp;
        exp        = 8'h3C;
        bus0.Din   = exp;
        bus0.Start = 1'b1;
        tick();
        bus0.Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus0.Svalid !== 1'b1 || bus0.Sout !== exp[i]) begin
                bad++;
                $display("FAIL bp_bit%0d got Svalid=%b Sout=%b want 1 %b",
                         i, bus0.Svalid, bus0.Sout, exp[i]);
            end
            tick();
        end
        bus0.Sready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            total++;
            if (bus0.Svalid !== 1'b1 || bus0.Sout !== exp[2] || bus0.Done !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall%0d got Svalid=%b Sout=%b Done=%b want 1 %b 0",
                         s, bus0.Svalid, bus0.Sout, bus0.Done, exp[2]);
            end
        end
        bus0.Sready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            total++;
            if (bus0.Svalid !== 1'b1 || bus0.Sout !== exp[i]) begin
                bad++;
                $display("FAIL bp_bit%0d got Svalid=%b Sout=%b want 1 %b",
                         i, bus0.Svalid, bus0.Sout, exp[i]);
            end
            tick();
        end
        total++;
        if (bus0.Done !== 1'b1 || bus0.Svalid !== 1'b0) begin
            bad++;
            $display("FAIL bp_done got Done=%b Svalid=%b want 1 0", bus0.Done, bus0.Svalid);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        logic [7:0] exp;
        exp        = 8'hC3;
        bus0.Din   = exp;
        bus0.Start = 1'b1;
        tick();
        bus0.Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 4) begin
                bus0.Start = 1'b1;
                bus0.Din   = 8'h00;
            end else begin
                bus0.Start = 1'b0;
            end
            total++;
            if (bus0.Svalid !== 1'b1 || bus0.Sout !== exp[i]) begin
                bad++;
                $display("FAIL busy_bit%0d got Svalid=%b Sout=%b want 1 %b",
                         i, bus0.Svalid, bus0.Sout, exp[i]);
            end
            tick();
        end
        // Start raised during DONE must not be taken on the DONE->IDLE edge.
        bus0.Start = 1'b1;
        total++;
        if (bus0.Done !== 1'b1) begin
            bad++;
            $display("FAIL busy_done got Done=%b want 1", bus0.Done);
        end
        tick();
        bus0.Start = 1'b0;
        total++;
        if (bus0.Busy !== 1'b0 || bus0.Svalid !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_in_done got Busy=%b Svalid=%b want 0 0",
                     bus0.Busy, bus0.Svalid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        exp        = 8'h5A;
        bus0.Din   = exp;
        bus0.Start = 1'b1;
        tick();
        bus0.Din = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus0.Sout !== exp[i]) begin
                bad++;
                $display("FAIL b2b_bit%0d got Sout=%b want %b", i, bus0.Sout, exp[i]);
            end
            tick();
        end
        tick();
        total++;
        if (bus0.Busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got Busy=%b want 0", bus0.Busy);
        end
        tick();
        bus0.Start = 1'b0;
        total++;
        if (bus0.Svalid !== 1'b1 || bus0.Sout !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart got Svalid=%b Sout=%b want 1 1", bus0.Svalid, bus0.Sout);
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        int         dones;
        exp        = 8'hF0;
        bus0.Din   = exp;
        bus0.Start = 1'b1;
        tick();
        bus0.Start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (bus0.Svalid !== 1'b0 || bus0.Busy !== 1'b0 || bus0.Done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got Svalid=%b Busy=%b Done=%b want 0 0 0",
                     bus0.Svalid, bus0.Busy, bus0.Done);
        end
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus0.Done === 1'b1 || bus0.Svalid === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL rstmid_no_done got %0d cycles with Done/Svalid want 0", dones);
        end
        exp        = 8'h0F;
        bus0.Din   = exp;
        bus0.Start = 1'b1;
        tick();
        bus0.Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus0.Svalid !== 1'b1 || bus0.Sout !== exp[i]) begin
                bad++;
                $display("FAIL rstmid_fresh_bit%0d got Svalid=%b Sout=%b want 1 %b",
                         i, bus0.Svalid, bus0.Sout, exp[i]);
            end
            tick();
        end
        total++;
        if (bus0.Done !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_fresh_done got Done=%b want 1", bus0.Done);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_msb_first();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
